inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 100 ++++++++++
 rtl/inst_fetch.sv | 156 +++++++++++++++
 tb/tb_inst_fetch.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions for the CPU front end.
//   fetch_state_t    : instruction fetch FSM encoding
//   RESET_PC_DEFAULT : default first fetch address after reset
//   PC_INC           : sequential fetch stride (one 32-bit word)
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode: DEPTH entries of {PC, IR}
// (plus an address-error flag when FETCH_ADDR_ERR_EN is defined).
// Ports:
//   clk, rst            : clock, async active-high reset
//   flush               : empty the buffer; a same-cycle push lands in a fresh buffer
//   push, push_pc/ir/err: write one entry at the tail (caller guarantees room)
//   pop                 : retire the head entry
//   head_pc/ir/err      : head entry, combinational
//   count               : number of valid entries
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   push_pc,
    input  logic [31:0]   push_ir,
`ifdef FETCH_ADDR_ERR_EN
    input  logic          push_err,
    output logic          head_err,
`endif
    output logic [31:0]   head_pc,
    output logic [31:0]   head_ir,
    output logic [CW-1:0] count
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [31:0]   pc_mem [DEPTH];
    logic [31:0]   ir_mem [DEPTH];
`ifdef FETCH_ADDR_ERR_EN
    logic          err_mem [DEPTH];
`endif
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i] <= '0;
                ir_mem[i] <= '0;
`ifdef FETCH_ADDR_ERR_EN
                err_mem[i] <= 1'b0;
`endif
            end
        end else if (flush) begin
            head <= '0;
            if (push) begin
                pc_mem[0] <= push_pc;
                ir_mem[0] <= push_ir;
`ifdef FETCH_ADDR_ERR_EN
                err_mem[0] <= push_err;
`endif
                tail  <= PTR_ONE;
                count <= CNT_ONE;
            end else begin
                tail  <= '0;
                count <= '0;
            end
        end else begin
            if (push) begin
                pc_mem[tail] <= push_pc;
                ir_mem[tail] <= push_ir;
`ifdef FETCH_ADDR_ERR_EN
                err_mem[tail] <= push_err;
`endif
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    assign head_pc = pc_mem[head];
    assign head_ir = ir_mem[head];
`ifdef FETCH_ADDR_ERR_EN
    assign head_err = err_mem[head];
`endif

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues single-outstanding word reads, buffers
// returned instructions and presents them to IF/ID with a valid/stall handshake.
// Optional feature macro: FETCH_ADDR_ERR_EN (misaligned redirect produces an
// error entry and halts fetch until the next redirect).
// Ports:
//   clk, rst                : clock, async active-high reset
//   redirect, redirect_pc   : flush and restart fetch at redirect_pc
//   stall                   : IF/ID does not accept this cycle
//   imem_req, imem_addr     : single-cycle read request and word address
//   imem_rvalid, imem_rdata : read response
//   valid_out, PC_out, IR_out, addr_err : presented instruction
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | no request outstanding
// ST_WAIT | one request outstanding, data will be kept
// ST_DROP | one request outstanding, data will be discarded
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_out,
    output logic [31:0] PC_out,
    output logic [31:0] IR_out,
    output logic        addr_err
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_t  state, state_nxt;
    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic [CW-1:0] count;
    logic [CW:0]   count_next;
    logic          rsp_keep;
    logic          push;
    logic          pop;
    logic          fetch_ok;
    logic [31:0]   push_pc;
    logic [31:0]   push_ir;

    assign valid_out = (count != '0);
    assign pop       = valid_out && !stall && !redirect;
    assign rsp_keep  = (state == ST_WAIT) && imem_rvalid && !redirect;

`ifdef FETCH_ADDR_ERR_EN
    logic misalign;
    logic halt;
    logic push_err;
    logic head_err;

    assign misalign  = redirect && (redirect_pc[1:0] != 2'b00);
    assign push      = rsp_keep || misalign;
    assign push_pc   = misalign ? redirect_pc : req_pc;
    assign push_ir   = misalign ? 32'h0 : imem_rdata;
    assign push_err  = misalign;
    assign fetch_ok  = !halt;
    assign imem_addr = pc;
    assign addr_err  = valid_out && head_err;

    // A misaligned target parks fetch until software redirects again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt <= 1'b0;
        end else if (redirect) begin
            halt <= misalign;
        end
    end
`else
    assign push      = rsp_keep;
    assign push_pc   = req_pc;
    assign push_ir   = imem_rdata;
    assign fetch_ok  = 1'b1;
    assign imem_addr = {pc[31:2], 2'b00};
    assign addr_err  = 1'b0;
`endif

    assign count_next = {1'b0, count} + (CW + 1)'(push) - (CW + 1)'(pop);

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        // Only request when the returning word is guaranteed a slot.
        if (!rst && !redirect && fetch_ok && (count_next < DEPTH_W) &&
            ((state == ST_IDLE) || ((state == ST_WAIT) && imem_rvalid))) begin
            imem_req = 1'b1;
        end
        unique case (state)
            ST_IDLE: begin
                if (imem_req) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect) begin
                    state_nxt = imem_rvalid ? ST_IDLE : ST_DROP;
                end else if (imem_rvalid) begin
                    state_nxt = imem_req ? ST_WAIT : ST_IDLE;
                end
            end
            ST_DROP: begin
                // The stale response retires the outstanding slot even if a
                // new redirect arrives with it; otherwise keep waiting.
                if (imem_rvalid) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                pc <= redirect_pc;
            end else if (imem_req) begin
                pc     <= pc + PC_INC;
                req_pc <= imem_addr;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .push     (push),
        .pop      (pop),
        .push_pc  (push_pc),
        .push_ir  (push_ir),
`ifdef FETCH_ADDR_ERR_EN
        .push_err (push_err),
        .head_err (head_err),
`endif
        .head_pc  (PC_out),
        .head_ir  (IR_out),
        .count    (count)
    );

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid_out;
    logic [31:0] PC_out;
    logic [31:0] IR_out;
    logic        addr_err;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    int          mem_lat  = 1;
    bit          pend_v   = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0;
    int          req_cnt  = 0;

    inst_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .valid_out   (valid_out),
        .PC_out      (PC_out),
        .IR_out      (IR_out),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    // Memory model: request seen mid-cycle, response mem_lat cycles later.
    always @(negedge clk) begin
        if (rst) begin
            pend_v = 1'b0;
        end else if (imem_req) begin
            pend_v    = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = mem_lat;
            req_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (pend_v) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pend_v      = 1'b0;
            end
        end
    end

    // Scoreboard: every accepted instruction must match the next expected PC.
    always @(negedge clk) begin
        if (!rst && valid_out && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_pop", 32'(exp_q.size()), 1);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc", PC_out, e);
                check("sb_ir", IR_out, mem_word(e));
                check("sb_err", {31'b0, addr_err}, 0);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic do_redirect(input logic [31:0] addr, input logic s);
        redirect    = 1'b1;
        redirect_pc = addr;
        stall       = s;
        step();
        redirect    = 1'b0;
    endtask

    task automatic settle;
        stall = 1'b1;
        repeat (4) step();
    endtask

    task automatic drain(input int budget, input bit rnd);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            step();
            t++;
            if (rnd && exp_q.size() != 0) stall = 1'($urandom_range(0, 1));
        end
        stall = 1'b1;
        check("drain", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'b0, imem_req}, 0);
        check({tag, "_valid"}, {31'b0, valid_out}, 0);
        check({tag, "_pc"},    PC_out, 0);
        check({tag, "_ir"},    IR_out, 0);
        check({tag, "_err"},   {31'b0, addr_err}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        // Reset values, then release with 1-cycle memory.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        push_seq(32'h0, 8);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rel_c1_req", {31'b0, imem_req}, 1);
        check("rel_c1_addr", imem_addr, 32'h0);
        check("rel_c1_valid", {31'b0, valid_out}, 0);
        @(negedge clk);
        check("rel_c2_addr", imem_addr, 32'h4);
        check("rel_c2_valid", {31'b0, valid_out}, 0);
        @(negedge clk);
        check("rel_c3_addr", imem_addr, 32'h8);
        check("rel_c3_valid", {31'b0, valid_out}, 1);
        check("rel_c3_pc", PC_out, 32'h0);
        step();
        drain(100, 1'b0);

        // Stall held: buffer fills to DEPTH and requests stop.
        settle();
        c0 = req_cnt;
        do_redirect(32'h0, 1'b1);
        repeat (5) step();
        @(negedge clk);
        check("stall_req", {31'b0, imem_req}, 0);
        check("stall_nreq", 32'(req_cnt - c0), 2);
        check("stall_valid", {31'b0, valid_out}, 1);
        check("stall_head", PC_out, 32'h0);
        step();
        push_seq(32'h0, 6);
        stall = 1'b0;
        drain(100, 1'b0);

        // Redirect while waiting; stale word arrives in DROP.
        settle();
        mem_lat = 2;
        do_redirect(32'h200, 1'b1);
        @(negedge clk);
        check("drop_req0", {31'b0, imem_req}, 1);
        check("drop_addr0", imem_addr, 32'h200);
        step();
        push_seq(32'h100, 4);
        do_redirect(32'h100, 1'b0);
        @(negedge clk);
        check("drop_noreq", {31'b0, imem_req}, 0);
        check("drop_novalid", {31'b0, valid_out}, 0);
        step();
        @(negedge clk);
        check("drop_req1", {31'b0, imem_req}, 1);
        check("drop_addr1", imem_addr, 32'h100);
        step();
        drain(100, 1'b0);
        mem_lat = 1;

        // Redirect coincident with rvalid.
        settle();
        do_redirect(32'h300, 1'b1);
        @(negedge clk);
        check("coin_addr0", imem_addr, 32'h300);
        step();
        push_seq(32'h380, 4);
        do_redirect(32'h380, 1'b0);
        @(negedge clk);
        check("coin_novalid", {31'b0, valid_out}, 0);
        check("coin_req", {31'b0, imem_req}, 1);
        check("coin_addr1", imem_addr, 32'h380);
        step();
        drain(100, 1'b0);

        // PC wrap at the top of the address space.
        settle();
        push_seq(32'hFFFF_FFF8, 5);
        do_redirect(32'hFFFF_FFF8, 1'b0);
        @(negedge clk);
        check("wrap_a0", imem_addr, 32'hFFFF_FFF8);
        step();
        @(negedge clk);
        check("wrap_a1", imem_addr, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        check("wrap_a2", imem_addr, 32'h0000_0000);
        step();
        drain(100, 1'b0);

        // Misaligned redirect target.
        settle();
`ifdef FETCH_ADDR_ERR_EN
        do_redirect(32'h102, 1'b1);
        @(negedge clk);
        check("mis_valid", {31'b0, valid_out}, 1);
        check("mis_pc", PC_out, 32'h102);
        check("mis_ir", IR_out, 32'h0);
        check("mis_err", {31'b0, addr_err}, 1);
        check("mis_req", {31'b0, imem_req}, 0);
        repeat (3) step();
        @(negedge clk);
        check("mis_hold_req", {31'b0, imem_req}, 0);
        check("mis_hold_valid", {31'b0, valid_out}, 1);
        step();
`else
        push_seq(32'h100, 3);
        do_redirect(32'h102, 1'b0);
        @(negedge clk);
        check("mis_addr", imem_addr, 32'h100);
        check("mis_err", {31'b0, addr_err}, 0);
        step();
        drain(100, 1'b0);
`endif

        // Streaming with random stall.
        settle();
        push_seq(32'h400, 16);
        do_redirect(32'h400, 1'b0);
        drain(300, 1'b1);

        // Reset asserted mid-run with a full buffer.
        settle();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        step();
        push_seq(32'h0, 4);
        stall = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check("mid_rel_req", {31'b0, imem_req}, 1);
        check("mid_rel_addr", imem_addr, 32'h0);
        step();
        drain(100, 1'b0);

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
